// File: rtl/port_arbiter.sv
// port_arbiter: round-robin arbiter that sequences one-cycle read/write accesses
// from N requesters onto a single shared bus-attached port register.
module port_arbiter #(
   parameter int N = 2,
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   req_we,
   input  logic [N*W-1:0] req_wdata,
   output logic [N-1:0]   grant,
   output logic [N-1:0]   ack,
   output logic [W-1:0]   rdata,
   output logic           busy,
   output logic           port_write,
   output logic           port_read,
   output logic [W-1:0]   bus_out,
   output logic           bus_oe,
   input  logic [W-1:0]   bus_in
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
   state_t state, state_n;
   logic [IW-1:0] last, last_n, win, idx;
   logic [N-1:0] cand, sel_n;
   logic found, we_n;
   logic [W-1:0] wdata_n;
   // last is both the round-robin pointer and the current owner once granted
   always_comb begin
      cand = req & ((state == ACK) ? ~(N'(1) << last) : '1);
      found = 1'b0;
      win = '0;
      idx = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last) + k) % N);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
      state_n = IDLE;
      last_n = last;
      we_n = 1'b0;
      wdata_n = '0;
      if (state == ACCESS) state_n = ACK;
      else if (found) begin
         state_n = ACCESS;
         last_n = win;
         we_n = req_we[win];
         wdata_n = req_wdata[win*W +: W];
      end
      sel_n = N'(1) << last_n;
   end
   // outputs are registered from next-state so every strobe is glitch-free
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         last <= IW'(N - 1);
         grant <= '0;
         ack <= '0;
         busy <= 1'b0;
         port_write <= 1'b0;
         port_read <= 1'b0;
         bus_oe <= 1'b0;
         bus_out <= '0;
         rdata <= '0;
      end else begin
         state <= state_n;
         last <= last_n;
         grant <= (state_n != IDLE) ? sel_n : '0;
         ack <= (state_n == ACK) ? sel_n : '0;
         busy <= state_n != IDLE;
         port_write <= state_n == ACCESS && we_n;
         port_read <= state_n == ACCESS && !we_n;
         bus_oe <= state_n == ACCESS && we_n;
         bus_out <= (state_n == ACCESS && we_n) ? wdata_n : '0;
         if (port_read) rdata <= bus_in;
      end
   end
endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: scoreboard bench for port_arbiter with a transaction-level
// arbitration model and a behavioural port register on the shared bus.
module tb_port_arbiter;
   localparam int N = 4;
   localparam int W = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] req = '0, req_we = '0, keep = '0, grant, ack;
   logic [N*W-1:0] req_wdata = '0;
   logic [W-1:0] rdata, bus_out, bus_in;
   logic [W-1:0] port_q = 16'h1234;
   logic busy, port_write, port_read, bus_oe;
   int checks = 0, failures = 0, cyc = 0;
   typedef struct {
      int id;
      logic we;
      logic [W-1:0] wdata;
      logic [W-1:0] rd;
      int ack_cyc;
   } txn_t;
   txn_t q[$];
   txn_t t;
   int m_last, m_phase, win;
   logic [N-1:0] cand;
   logic m_we;
   logic [W-1:0] m_wd, m_rd;
   logic [W-1:0] m_port = 16'h1234;
   logic have, e_acc, e_ack, e_we, pw_d, pr_d;
   logic [N-1:0] e_sel;
   logic [W-1:0] e_wd, e_rd;

   port_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_wdata(req_wdata),
      .grant(grant), .ack(ack), .rdata(rdata), .busy(busy), .port_write(port_write),
      .port_read(port_read), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
   );

   always #5 clk = ~clk;

   // the port register: keeps its contents across arbiter resets
   assign bus_in = port_read ? port_q : 16'hDEAD;
   always @(posedge clk) if (port_write) port_q <= bus_out;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // transaction model: each grant is a 2-cycle transfer; arbitration happens when free
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_last = N - 1;
         m_phase = 0;
         q.delete();
      end else begin
         cyc++;
         if (m_phase == 1) begin
            if (m_we) m_port = m_wd;
            m_phase = 2;
         end else begin
            cand = req;
            if (m_phase == 2) cand[m_last] = 1'b0;
            win = -1;
            for (int k = 1; k <= N; k++)
               if (win < 0 && cand[(m_last + k) % N]) win = (m_last + k) % N;
            if (win >= 0) begin
               t.id = win;
               t.we = req_we[win];
               t.wdata = req_wdata[win*W +: W];
               t.rd = m_port;
               t.ack_cyc = cyc + 1;
               q.push_back(t);
               m_we = t.we;
               m_wd = t.wdata;
               m_last = win;
               m_phase = 1;
            end else m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         check("reset_out", {grant, ack, busy, port_write, port_read, bus_oe}, '0);
         check("reset_bus", {bus_out, rdata}, '0);
         m_rd = '0;
         pw_d = 1'b0;
         pr_d = 1'b0;
      end else begin
         have = q.size() > 0;
         e_acc = have && q[0].ack_cyc == cyc + 1;
         e_ack = have && q[0].ack_cyc == cyc;
         e_sel = have ? (N'(1) << q[0].id) : '0;
         e_we = have ? q[0].we : 1'b0;
         e_wd = have ? q[0].wdata : '0;
         e_rd = have ? q[0].rd : '0;
         check("grant", grant, (e_acc || e_ack) ? e_sel : '0);
         check("ack", ack, e_ack ? e_sel : '0);
         check("busy", busy, e_acc || e_ack);
         check("port_write", port_write, e_acc && e_we);
         check("port_read", port_read, e_acc && !e_we);
         check("bus_oe", bus_oe, e_acc && e_we);
         check("bus_out", bus_out, (e_acc && e_we) ? e_wd : '0);
         check("strobe_excl", port_write & port_read, 0);
         check("strobe_adj", (port_write | port_read) & (pw_d | pr_d), 0);
         if (e_ack && !e_we) m_rd = e_rd;
         check("rdata", rdata, m_rd);
         if (e_ack) void'(q.pop_front());
         else if (have && cyc > q[0].ack_cyc) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: requester %0d got no ack by cycle %0d", q[0].id, cyc);
            void'(q.pop_front());
         end
         pw_d = port_write;
         pr_d = port_read;
      end
   end

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < N; i++) if (ack[i] && !keep[i]) req[i] = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((req != '0 || busy) && n < budget) begin
         step();
         n++;
      end
      check("drain", {req, busy}, '0);
   endtask

   task automatic pulse_reset();
      step();
      #2 reset = 1'b1;
      step();
      #2 reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int n, nacks;
      repeat (3) step();
      #2 reset = 1'b0;
      // read of the port reset value
      req_we[0] = 1'b0;
      req[0] = 1'b1;
      wait_done(10);
      check("read_reset_value", rdata, 16'h1234);
      // reset during the ACCESS of a write
      req_we[0] = 1'b1;
      req_wdata[15:0] = 16'h5A5A;
      req[0] = 1'b1;
      n = 0;
      while (!port_write && n < 10) begin
         step();
         n++;
      end
      check("rst_write_seen", port_write, 1);
      #2 reset = 1'b1;
      #1 check("rst_async", {grant, ack, busy, port_write, port_read, bus_oe}, '0);
      req_we[0] = 1'b0;
      req_we[3] = 1'b0;
      req[3] = 1'b1;
      step();
      step();
      check("rst_port_held", port_q, 16'h1234);
      #2 reset = 1'b0;
      wait_done(20);
      // write then read from requester 1
      req_we[1] = 1'b1;
      req_wdata[31:16] = 16'hBEEF;
      req[1] = 1'b1;
      wait_done(10);
      check("out_pin_beef", port_q, 16'hBEEF);
      req_we[1] = 1'b0;
      req[1] = 1'b1;
      wait_done(10);
      check("read_beef", rdata, 16'hBEEF);
      // contention between requesters 0 and 1
      req_we[1:0] = 2'b01;
      req_wdata[15:0] = 16'hC0DE;
      req[1:0] = 2'b11;
      wait_done(20);
      // round-robin fairness with everyone requesting
      pulse_reset();
      keep = '1;
      req = '1;
      nacks = 0;
      repeat (16) begin
         step();
         req_we = N'($urandom);
         req_wdata = {$urandom, $urandom};
         check("rr_busy", busy, 1);
         if (ack != '0) begin
            check("rr_order", ack, 1 << (nacks % 4));
            nacks++;
         end
      end
      check("rr_count", nacks, 8);
      keep = '0;
      wait_done(40);
      // owner masking: requester 2 holds req through its ACK
      keep[2] = 1'b1;
      req[2] = 1'b1;
      step();
      step();
      step();
      check("mask_idle", busy, 0);
      step();
      check("mask_regrant", grant, 4'b0100);
      keep = '0;
      wait_done(10);
      // randomized traffic
      repeat (300) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
            else if (req[i] && grant[i] && !ack[i] && $urandom_range(0, 3) == 0) req[i] = 1'b0;
            keep[i] = $urandom_range(0, 4) == 0;
         end
         req_we = N'($urandom);
         req_wdata = {$urandom, $urandom};
      end
      keep = '0;
      wait_done(40);
      check("port_model", port_q, m_port);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/port_arbiter.md
# port_arbiter

Round-robin arbiter and access sequencer that shares one bus-attached I/O port register (16-bit, read/write-enabled, tri-state bus output) between N requesters, such as the CPU control unit and a DMA engine. It grants one requester at a time, drives the port's `write`/`read` strobes and the shared data bus for exactly one cycle, captures read data, and returns a one-cycle acknowledge. It sits between the requesters and the port, and is the only block that asserts the port's strobes.

## Interface
- `N`, default 2: number of requesters, 2..8.
- `W`, default 16: data width; must match the port register.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in N: request level, one bit per requester; held high until the matching `ack`.
- `req_we` in N: 1 = write to port, 0 = read from port; sampled at grant.
- `req_wdata` in N*W: packed write data; requester i uses bits [i*W +: W].
- `grant` out N: one-hot, high during the ACCESS and ACK cycles of the granted requester.
- `ack` out N: one-hot, one-cycle pulse in the ACK cycle.
- `rdata` out W: last captured read data; valid with `ack` for reads and held until the next read capture.
- `busy` out 1: high in ACCESS and ACK.
- `port_write` out 1: port write strobe.
- `port_read` out 1: port read strobe; the port drives the bus while this is high.
- `bus_out` out W: data driven onto the shared bus.
- `bus_oe` out 1: bus output enable; equals `port_write`.
- `bus_in` in W: resolved shared bus value.

## Operation
- FSM states: IDLE, ACCESS, ACK. All outputs are registered.
- **IDLE**
  - If any `req` bit is high, select winner g by round-robin and go to ACCESS.
  - On entry to ACCESS, latch g, `we = req_we[g]` and `wdata = req_wdata[g]`.
  - If no `req` bit is high, stay in IDLE.
- **Round-robin**
  - Search starts at `last+1` (mod N) and takes the first set bit.
  - `last` updates to g at every grant.
  - Reset value of `last` is N-1, so requester 0 has top priority after reset.
- **ACCESS** (exactly 1 cycle)
  - `grant[g]` = 1 and `busy` = 1.
  - Write: `port_write` = 1, `bus_oe` = 1, `bus_out` = latched wdata, `port_read` = 0.
  - Read: `port_read` = 1, `bus_oe` = 0; `rdata` <= `bus_in` at the end of the cycle.
  - Always go to ACK next.
- **ACK** (exactly 1 cycle)
  - `ack[g]` = 1, `grant[g]` = 1, `busy` = 1; both strobes 0.
  - Arbitrate over `req & ~(1<<g)`, i.e. the current owner is masked.
  - If the masked set is nonzero, go directly to ACCESS with the new winner; otherwise go to IDLE.
- **Mid-transfer changes**
  - A requester that drops `req` during ACCESS or ACK still completes and receives `ack`.
  - `req_we` and `req_wdata` changes after grant are ignored.
- `bus_out` = 0 whenever `bus_oe` = 0.
- **Reset values**
  - State IDLE, `grant` = 0, `ack` = 0, `busy` = 0.
  - `port_write` = 0, `port_read` = 0, `bus_oe` = 0, `bus_out` = 0.
  - `rdata` = 0, `last` = N-1.
- **Reset mid-operation**
  - All outputs go to reset values immediately (asynchronous).
  - An in-flight transfer is dropped with no `ack`; a write not yet clocked into the port is lost.
- Requests are not queued. A requester is served only while its `req` is high at an arbitration point (IDLE or ACK).

## Timing
- Latency from request to `ack`:
  - `req[i]` rises with the FSM in IDLE and is sampled at edge k.
  - ACCESS occupies cycle k..k+1.
  - `ack[i]` is high in cycle k+1..k+2.
  - With no other request, the FSM is in IDLE from edge k+2.
- The port register captures write data at the edge ending ACCESS.
- Read data is captured at the edge ending ACCESS and is visible on `rdata` in the ACK cycle.
- Back-to-back service gives one transfer per 2 cycles: the ACK of one transfer is followed immediately by the ACCESS of the next.
- Fairness: with all N requesting continuously, each requester is served once every 2N cycles.
- `port_write` and `port_read` are never high together and are never high in two consecutive cycles.

## Test plan
- **Read after reset:** pulse reset, then requester 0 reads (`req_we[0]`=0). Required: one `port_read` pulse, `ack[0]` 2 cycles after the request, `rdata` = 16'h1234 (the port reset value).
- **Write then read:** requester 1 writes 16'hBEEF (one `port_write` cycle, `bus_out` = BEEF, `bus_oe` = 1), then reads. Required: `rdata` = 16'hBEEF and the port's `out_pin` = BEEF.
- **Contention:** `req` = 2'b11 held continuously, each requester dropping its bit after its own `ack`. Required: grant order 0, 1; acks 2 cycles apart; no IDLE cycle between the two transfers.
- **Round-robin fairness:** N=4, all requests held high for 16 cycles. Required: acks in order 0, 1, 2, 3, 0, 1, 2, 3; `busy` = 1 throughout; strobes never adjacent.
- **Owner masking:** one requester keeps `req` high through its ACK cycle. Required: FSM goes to IDLE rather than a spurious second grant; the next grant comes at the following arbitration point.
- **Reset mid-operation:** assert reset during the ACCESS of a write of 16'h5A5A. Required: strobes, `grant` and `ack` drop immediately; no `ack` is issued; the port holds 16'h1234; after reset release requester 0 has top priority.
